// File: rtl/rom_read_arbiter.sv
// Shares one 1-cycle registered ROM among NUM_REQ requesters with a round-robin grant and one-hot tagged responses.
// Define ROM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module rom_read_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ADDR_WIDTH-1:0]         rom_raddr,
  input  logic [DATA_WIDTH-1:0]         rom_q
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    grant;
  logic [PTR_W-1:0]      idx;
  logic [PTR_W-1:0]      win_id;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  found;
  logic                  vld_p1, vld_p2;
  logic [PTR_W-1:0]      id_p1, id_p2;
`ifndef ROM_ARB_FIXED_PRIO_EN
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      nxt_ptr;
`endif

  // Stage p0: pick the first valid requester, searching upward from the priority pointer.
  always_comb begin
    grant    = '0;
    idx      = '0;
    win_id   = '0;
    win_addr = '0;
    found    = 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
    nxt_ptr  = '0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      idx = PTR_W'(k);
`else
      idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
`endif
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        win_id      = idx;
        win_addr    = req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH];
`ifndef ROM_ARB_FIXED_PRIO_EN
        nxt_ptr     = PTR_W'((int'(idx) + 1) % NUM_REQ);
`endif
      end
    end
  end

  assign req_ready = rst_n ? grant : '0;

  // Stage p1: accepted address goes to the ROM; stage p2 tracks the ROM's own output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_raddr <= '0;
      vld_p1    <= 1'b0;
      id_p1     <= '0;
      vld_p2    <= 1'b0;
      id_p2     <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      vld_p1 <= found;
      if (found) begin
        rom_raddr <= win_addr;
        id_p1     <= win_id;
`ifndef ROM_ARB_FIXED_PRIO_EN
        rr_ptr    <= nxt_ptr;
`endif
      end
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
    end
  end

  // Stage p2 output: rom_q is already registered, so only the tag is decoded here.
  always_comb begin
    rsp_valid = '0;
    if (vld_p2) rsp_valid[id_p2] = 1'b1;
  end

  assign rsp_data = rom_q;

endmodule
